// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encodings and parameter defaults.
package program_loader_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen   = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  localparam logic [31:0] DefaultBaseAddr = 32'h0000_0000;
  localparam logic [31:0] DefaultAddrStep = 32'd4;
  localparam int unsigned DefaultMaxWords = 256;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory load port of the boot loader.
interface program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_enable;
  logic [31:0] load_address;
  logic [31:0] load_data;

  // Host / memory side.
  modport master (
    output in_valid, in_data,
    input  in_ready, load_enable, load_address, load_data
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, load_enable, load_address, load_data
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects four LSB-first bytes into a 32-bit word; word is valid in the cycle the 4th byte lands.
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt_q;
  // Only the first three bytes need storage; the 4th is merged live so the word
  // is available on the same edge that accepts it.
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      shift_q    <= {data, shift_q[23:8]};
    end
  end

  always_comb begin
    word_valid = accept && (byte_cnt_q == 2'd3);
    word       = {data, shift_q};
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream in, 32-bit words written to instruction memory,
// then fetch_enable released once the whole program has been stored.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter logic [31:0] ADDR_STEP = DefaultAddrStep,
  parameter int unsigned MAX_WORDS = DefaultMaxWords
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  program_loader_if.slave        bus,
  output logic                   fetch_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  logic [2:0]  state_q, state_d;
  logic [31:0] word_idx_q;
  logic [31:0] len_q;
  logic [31:0] load_address_q;
  logic [31:0] load_data_q;

  logic        start_accept;
  logic        accept;
  logic        word_valid;
  logic [31:0] word;
  logic [31:0] word_idx_next;

  assign start_accept  = start && ((state_q == StIdle) || (state_q == StDone) ||
                                   (state_q == StErr));
  assign accept        = bus.in_valid && bus.in_ready;
  assign word_idx_next = word_idx_q + 32'd1;

  program_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .accept     (accept),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StLen;
      StLen: begin
        if (word_valid) begin
          state_d = ((word == 32'd0) || (word > MAX_WORDS)) ? StErr : StData;
        end
      end
      StData:  if (word_valid) state_d = StWrite;
      StWrite: state_d = (word_idx_next == len_q) ? StDone : StData;
      StDone:  if (start) state_d = StLen;
      StErr:   if (start) state_d = StLen;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      word_idx_q     <= 32'd0;
      len_q          <= 32'd0;
      load_address_q <= BASE_ADDR;
      load_data_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start_accept) begin
        word_idx_q <= 32'd0;
        len_q      <= 32'd0;
      end
      if ((state_q == StLen) && word_valid) begin
        len_q <= word;
      end
      // Address and data move only when a word is handed to the memory.
      if ((state_q == StData) && word_valid) begin
        load_data_q    <= word;
        load_address_q <= BASE_ADDR + word_idx_q * ADDR_STEP;
      end
      if (state_q == StWrite) begin
        word_idx_q <= word_idx_next;
      end
    end
  end

  always_comb begin
    bus.in_ready     = (state_q == StLen) || (state_q == StData);
    bus.load_enable  = (state_q == StWrite);
    bus.load_address = load_address_q;
    bus.load_data    = load_data_q;
    fetch_enable     = (state_q == StDone);
    done             = (state_q == StDone);
    error            = (state_q == StErr);
    busy             = (state_q == StLen) || (state_q == StData) || (state_q == StWrite);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of load sessions plus hand-written corner sequences.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic fetch_enable, busy, done, error;

  program_loader_if bus ();

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .fetch_enable (fetch_enable),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t writes[$];

  always @(negedge clk) begin
    if (bus.load_enable) writes.push_back({bus.load_address, bus.load_data});
  end

  typedef struct {
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_err;
    bit          gaps;
  } vec_t;

  vec_t vecs[5];
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        step();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 20 && !bus.in_ready; n++) step();
    if (!bus.in_ready) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_load_enable"}, {31'd0, bus.load_enable}, 32'd0);
    check({tag, "_fetch_enable"}, {31'd0, fetch_enable}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_load_address"}, bus.load_address, 32'h0000_0000);
    check({tag, "_load_data"}, bus.load_data, 32'h0000_0000);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_start_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_start_done"}, {31'd0, done}, 32'd0);
    check({tag, "_start_fetch"}, {31'd0, fetch_enable}, 32'd0);
    check({tag, "_start_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp_data;
    writes.delete();
    do_start(tag);
    send_word(v.len, v.gaps);
    if (v.exp_err) begin
      check({tag, "_error"}, {31'd0, error}, 32'd1);
      check({tag, "_err_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_err_fetch"}, {31'd0, fetch_enable}, 32'd0);
      step();
      step();
      check({tag, "_error_held"}, {31'd0, error}, 32'd1);
      check({tag, "_no_writes"}, writes.size(), 32'd0);
    end else begin
      for (int i = 0; i < int'(v.len); i++) begin
        send_word((i == 0) ? v.w0 : v.w1, v.gaps);
        check({tag, "_write_strobe"}, {31'd0, bus.load_enable}, 32'd1);
        check({tag, "_write_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      end
      step();
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_fetch"}, {31'd0, fetch_enable}, 32'd1);
      check({tag, "_strobe_off"}, {31'd0, bus.load_enable}, 32'd0);
      check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      check({tag, "_write_count"}, writes.size(), v.len);
      for (int i = 0; i < writes.size() && i < int'(v.len); i++) begin
        exp_data = (i == 0) ? v.w0 : v.w1;
        check({tag, "_addr"}, writes[i].addr, 32'(4 * i));
        check({tag, "_data"}, writes[i].data, exp_data);
      end
    end
  endtask

  initial begin
    int errs;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{len: 32'd2, w0: 32'h0000_0513, w1: 32'h0010_0093, exp_err: 1'b0, gaps: 1'b0};
    vecs[1] = '{len: 32'd2, w0: 32'h0000_0513, w1: 32'h0010_0093, exp_err: 1'b0, gaps: 1'b1};
    vecs[2] = '{len: 32'd0, w0: 32'h0, w1: 32'h0, exp_err: 1'b1, gaps: 1'b0};
    vecs[3] = '{len: 32'd257, w0: 32'h0, w1: 32'h0, exp_err: 1'b1, gaps: 1'b1};
    vecs[4] = '{len: 32'd1, w0: 32'hDEAD_BEEF, w1: 32'h0, exp_err: 1'b0, gaps: 1'b0};

    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
    step();
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-word, then a fresh load.
    do_start("rst");
    send_word(32'd1, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1;
    step();
    check_reset_values("midreset");
    reset = 1'b0;
    step();
    run_vec(vecs[0], "reload");

    // start during DATA is ignored; start in DONE re-enters LEN.
    writes.delete();
    do_start("ign");
    send_word(32'd2, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("ign_strobe", {31'd0, bus.load_enable}, 32'd1);
    check("ign_addr0", bus.load_address, 32'h0);
    check("ign_data0", bus.load_data, 32'h0000_0513);
    send_word(32'h0010_0093, 1'b0);
    step();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_count", writes.size(), 32'd2);
    check("ign_hold_addr", bus.load_address, 32'h4);
    check("ign_hold_data", bus.load_data, 32'h0010_0093);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_fetch", {31'd0, fetch_enable}, 32'd0);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Maximum-length program, data equal to word index.
    writes.delete();
    do_start("max");
    send_word(32'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
    step();
    check("max_done", {31'd0, done}, 32'd1);
    check("max_fetch", {31'd0, fetch_enable}, 32'd1);
    check("max_count", writes.size(), 32'd256);
    if (writes.size() == 256) begin
      check("max_last_addr", writes[255].addr, 32'h0000_03FC);
      check("max_last_data", writes[255].data, 32'd255);
    end
    errs = 0;
    for (int i = 0; i < writes.size(); i++) begin
      if (writes[i].addr !== 32'(4 * i) || writes[i].data !== 32'(i)) errs++;
    end
    check("max_all_words", 32'(errs), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
